imem_loader: RTL and testbench

//  Writer side of the instruction-memory fetch path. Accepts a program byte-by-byte from external

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - pin-driven imem program loader; holds core in reset while loading.
// Optional IMEM_LOADER_CSUM_EN: accept a trailing XOR checksum byte and flag a mismatch as load_err.
module imem_loader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              byte_stb,
  input  logic [DATA_W-1:0] byte_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              byte_ack,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_REL} state_t;

  state_t            state, state_n;
  logic [SYNC_STAGES-1:0] req_sync, stb_sync;
  logic              req_s, stb_s, stb_prev, stb_rise;
  logic [ADDR_W-1:0] addr, addr_n, waddr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              we_n, ack_n, done_n, err_n;
`ifdef IMEM_LOADER_CSUM_EN
  logic [DATA_W-1:0] csum, csum_n;
  logic              csum_phase, csum_phase_n;
`endif

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign stb_s     = stb_sync[SYNC_STAGES-1];
  assign core_hold = (state != IDLE);

  // stb_rise is registered so byte_in is sampled well inside its stable window
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync   <= '0;
      stb_sync   <= '0;
      stb_prev   <= 1'b0;
      stb_rise   <= 1'b0;
      state      <= IDLE;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      byte_ack   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      req_sync   <= {req_sync[SYNC_STAGES-2:0], load_req};
      stb_sync   <= {stb_sync[SYNC_STAGES-2:0], byte_stb};
      stb_prev   <= stb_s;
      stb_rise   <= stb_s & ~stb_prev;
      state      <= state_n;
      addr       <= addr_n;
      imem_we    <= we_n;
      imem_addr  <= waddr_n;
      imem_wdata <= wdata_n;
      byte_ack   <= ack_n;
      load_done  <= done_n;
      load_err   <= err_n;
`ifdef IMEM_LOADER_CSUM_EN
      csum       <= csum_n;
      csum_phase <= csum_phase_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    we_n    = 1'b0;
    waddr_n = imem_addr;
    wdata_n = imem_wdata;
    ack_n   = byte_ack & stb_s;
    done_n  = load_done;
    err_n   = load_err;
`ifdef IMEM_LOADER_CSUM_EN
    csum_n       = csum;
    csum_phase_n = csum_phase;
`endif
    case (state)
      IDLE: begin
        if (req_s) begin
          state_n = LOAD;
          addr_n  = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_n       = '0;
          csum_phase_n = 1'b0;
`endif
        end
      end
      LOAD: begin
        // abort wins over a same-cycle strobe
        if (!req_s) begin
          state_n = IDLE;
          err_n   = 1'b0 | 1'b1;
          done_n  = 1'b0;
          ack_n   = 1'b0;
        end else if (stb_rise) begin
          ack_n = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          if (csum_phase) begin
            state_n = WAIT_REL;
            if (byte_in == csum) done_n = 1'b1;
            else                 err_n  = 1'b1;
          end else begin
            we_n    = 1'b1;
            waddr_n = addr;
            wdata_n = byte_in;
            csum_n  = csum ^ byte_in;
            if (addr == LAST_ADDR) csum_phase_n = 1'b1;
            else                   addr_n = addr + 1'b1;
          end
`else
          we_n    = 1'b1;
          waddr_n = addr;
          wdata_n = byte_in;
          if (addr == LAST_ADDR) begin
            state_n = WAIT_REL;
            done_n  = 1'b1;
          end else begin
            addr_n = addr + 1'b1;
          end
`endif
        end
      end
      WAIT_REL: begin
        if (!req_s) begin
          state_n = IDLE;
          ack_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed, table-driven bench for imem_loader.
// Honours IMEM_LOADER_CSUM_EN when defined for the checksum byte behaviour.
module tb_imem_loader;

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load_req;
  logic       byte_stb;
  logic [7:0] byte_in;
  logic       imem_we;
  logic [3:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       core_hold;
  logic       byte_ack;
  logic       load_done;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [7:0] b;
    logic [3:0] exp_a;
    logic [7:0] exp_d;
    logic       exp_done;
  } vec_t;
  vec_t tbl[16];

  imem_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .byte_stb  (byte_stb),
    .byte_in   (byte_in),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold (core_hold),
    .byte_ack  (byte_ack),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && imem_we) wq.push_back({imem_addr, imem_wdata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in  = b;
    byte_stb = 1'b1;
    edges(5);
    byte_stb = 1'b0;
    edges(5);
  endtask

  task automatic chk_last_write(input string name, input int n0, input logic [3:0] a, input logic [7:0] d);
    chk({name, "_cnt"}, 32'(wq.size()), 32'(n0 + 1));
    if (wq.size() == n0 + 1) begin
      chk({name, "_addr"}, 32'(wq[n0].a), 32'(a));
      chk({name, "_data"}, 32'(wq[n0].d), 32'(d));
    end
  endtask

  task automatic start_session();
    load_req = 1'b1;
    edges(2);
    chk("hold_pre_start", 32'(core_hold), 32'd0);
    edges(1);
    chk("hold_start", 32'(core_hold), 32'd1);
    chk("done_clr_start", 32'(load_done), 32'd0);
    chk("err_clr_start", 32'(load_err), 32'd0);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{8'(i + 1), 4'(i), 8'(i + 1), (i == 15) && !CSUM};

    rst = 1'b1; load_req = 1'b0; byte_stb = 1'b0; byte_in = 8'h00;
    edges(3);
    chk("rst_we",   32'(imem_we),    32'd0);
    chk("rst_addr", 32'(imem_addr),  32'd0);
    chk("rst_data", 32'(imem_wdata), 32'd0);
    chk("rst_hold", 32'(core_hold),  32'd0);
    chk("rst_ack",  32'(byte_ack),   32'd0);
    chk("rst_done", 32'(load_done),  32'd0);
    chk("rst_err",  32'(load_err),   32'd0);
    rst = 1'b0;
    edges(2);

    // strobes while idle must not write
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
    chk("idle_writes", 32'(wq.size()), 32'd0);
    chk("idle_hold", 32'(core_hold), 32'd0);
    chk("idle_ack", 32'(byte_ack), 32'd0);

    // full load from the vector table
    start_session();
    for (int i = 0; i < 16; i++) begin
      n0 = wq.size();
      send_byte(tbl[i].b);
      chk_last_write($sformatf("full%0d", i), n0, tbl[i].exp_a, tbl[i].exp_d);
      chk($sformatf("full%0d_done", i), 32'(load_done), 32'(tbl[i].exp_done));
      chk($sformatf("full%0d_hold", i), 32'(core_hold), 32'd1);
    end
    if (CSUM) begin
      n0 = wq.size();
      send_byte(8'h10);
      chk("csum_ok_nowrite", 32'(wq.size()), 32'(n0));
      chk("csum_ok_done", 32'(load_done), 32'd1);
      chk("csum_ok_err", 32'(load_err), 32'd0);
    end
    n0 = wq.size();
    send_byte(8'hF1);
    send_byte(8'hF2);
    chk("extra_writes", 32'(wq.size()), 32'(n0));
    chk("extra_done", 32'(load_done), 32'd1);
    load_req = 1'b0;
    edges(2);
    chk("rel_hold_pre", 32'(core_hold), 32'd1);
    edges(1);
    chk("rel_hold", 32'(core_hold), 32'd0);
    chk("rel_done_held", 32'(load_done), 32'd1);
    edges(2);

    // latency and ack timing on the first byte of a new session
    start_session();
    n0 = wq.size();
    byte_in = 8'hA0;
    byte_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edges(1);
      chk($sformatf("lat_we%0d", i), 32'(imem_we), 32'(i == 3));
      chk($sformatf("lat_ack%0d", i), 32'(byte_ack), 32'(i >= 3));
    end
    byte_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edges(1);
      chk($sformatf("ack_fall%0d", i), 32'(byte_ack), 32'(i < 2));
    end
    chk_last_write("lat", n0, 4'd0, 8'hA0);

    // abort after five bytes
    for (int i = 1; i < 5; i++) begin
      n0 = wq.size();
      send_byte(8'hA0 + 8'(i));
      chk_last_write($sformatf("ab%0d", i), n0, 4'(i), 8'hA0 + 8'(i));
    end
    load_req = 1'b0;
    edges(3);
    chk("abort_err", 32'(load_err), 32'd1);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_hold", 32'(core_hold), 32'd0);
    n0 = wq.size();
    send_byte(8'hBB);
    chk("abort_nowrite", 32'(wq.size()), 32'(n0));
    chk("abort_err_held", 32'(load_err), 32'd1);

    // new session restarts at 0; reset lands mid-session at byte 7
    start_session();
    for (int i = 0; i < 7; i++) begin
      n0 = wq.size();
      send_byte(8'h50 + 8'(i));
      chk_last_write($sformatf("rs%0d", i), n0, 4'(i), 8'h50 + 8'(i));
    end
    rst = 1'b1;
    edges(1);
    chk("mrst_hold", 32'(core_hold), 32'd0);
    chk("mrst_we", 32'(imem_we), 32'd0);
    chk("mrst_addr", 32'(imem_addr), 32'd0);
    chk("mrst_data", 32'(imem_wdata), 32'd0);
    chk("mrst_ack", 32'(byte_ack), 32'd0);
    chk("mrst_done", 32'(load_done), 32'd0);
    chk("mrst_err", 32'(load_err), 32'd0);
    rst = 1'b0;
    load_req = 1'b0;
    edges(3);
    start_session();
    n0 = wq.size();
    send_byte(8'h77);
    chk_last_write("post_rst", n0, 4'd0, 8'h77);

    if (CSUM) begin
      load_req = 1'b0;
      edges(4);
      start_session();
      for (int i = 0; i < 16; i++) send_byte(tbl[i].b);
      n0 = wq.size();
      send_byte(8'h11);
      chk("csum_bad_nowrite", 32'(wq.size()), 32'(n0));
      chk("csum_bad_err", 32'(load_err), 32'd1);
      chk("csum_bad_done", 32'(load_done), 32'd0);
      chk("csum_bad_hold", 32'(core_hold), 32'd1);
    end

    load_req = 1'b0;
    edges(4);
    chk("final_hold", 32'(core_hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
